// File: rtl/alu_mdu_seq_if.sv
// rtl/alu_mdu_seq_if.sv - start/busy/valid operand and result bundle for alu_mdu_seq
interface alu_mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             kill;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, kill, op, a, b,
    input  busy, valid, result, zero
  );

  modport slave (
    input  start, kill, op, a, b,
    output busy, valid, result, zero
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - registered ALU with iterative radix-2 RV32M multiply/divide
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  localparam int CNTW = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mdu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CNTW-1:0]    cnt;
  logic [1:0]         opl_q;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_res;
  logic               neg_rem;
  logic               busy_q;
  logic               valid_q;
  logic               zero_q;
  logic [WIDTH-1:0]   result_q;

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.zero   = zero_q;
  assign bus.result = result_q;

  logic             is_mul, is_div, a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, single_res, special_res;
  logic [SW-1:0]    shamt;

  always_comb begin
    is_mul   = (bus.op[4:2] == 3'b100);
    is_div   = (bus.op[4:2] == 3'b101);
    // MUL/MULH/MULHSU sign-extend A, only MUL/MULH sign-extend B; DIV/REM have op[0]=0
    a_sgn    = is_mul ? (bus.op[1:0] != 2'b11) : ~bus.op[0];
    b_sgn    = is_mul ? ~bus.op[1] : ~bus.op[0];
    neg_a    = a_sgn & bus.a[WIDTH-1];
    neg_b    = b_sgn & bus.b[WIDTH-1];
    abs_a    = neg_a ? -bus.a : bus.a;
    abs_b    = neg_b ? -bus.b : bus.b;
    div_zero = (bus.b == '0);
    div_ovf  = ~bus.op[0] & (bus.a == MIN_NEG) & (&bus.b);
    special_res = bus.op[1] ? (div_zero ? bus.a : '0) : (div_zero ? '1 : bus.a);
    shamt    = bus.b[SW-1:0];
    case (bus.op)
      5'd0:    single_res = bus.a & bus.b;
      5'd1:    single_res = bus.a | bus.b;
      5'd2:    single_res = bus.a + bus.b;
      5'd3:    single_res = bus.a - bus.b;
      5'd4:    single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      5'd5:    single_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      5'd6:    single_res = bus.a ^ bus.b;
      5'd7:    single_res = bus.a << shamt;
      5'd8:    single_res = bus.a >> shamt;
      5'd9:    single_res = $signed(bus.a) >>> shamt;
      default: single_res = '0;
    endcase
  end

  logic [2*WIDTH-1:0] prod_step, prod_fin;
  logic [WIDTH-1:0]   mul_res, div_res, rem_next, quot_next;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               take;

  always_comb begin
    prod_step = mplier[0] ? (prod + mcand) : prod;
    prod_fin  = neg_res ? -prod_step : prod_step;
    mul_res   = (opl_q == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
    // restoring step: dividend bits shift out of quot's top, quotient bits in at the bottom
    rem_sh    = {rem, quot[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, dvsr};
    take      = ~rem_diff[WIDTH];
    rem_next  = take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], take};
    div_res   = opl_q[1] ? (neg_rem ? -rem_next : rem_next)
                         : (neg_res ? -quot_next : quot_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opl_q    <= '0;
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      quot     <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            opl_q  <= bus.op[1:0];
            zero_q <= (bus.a == bus.b);
            busy_q <= 1'b1;
            if (is_mul) begin
              state   <= MUL;
              cnt     <= CNTW'(WIDTH);
              mcand   <= {{WIDTH{1'b0}}, abs_a};
              mplier  <= abs_b;
              prod    <= '0;
              neg_res <= neg_a ^ neg_b;
            end else if (is_div && !div_zero && !div_ovf) begin
              state   <= DIV;
              cnt     <= CNTW'(WIDTH);
              quot    <= abs_a;
              rem     <= '0;
              dvsr    <= abs_b;
              neg_res <= neg_a ^ neg_b;
              neg_rem <= neg_a;
            end else begin
              state    <= DONE;
              valid_q  <= 1'b1;
              result_q <= is_div ? special_res : single_res;
            end
          end
        end
        MUL: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
              state    <= DONE;
              valid_q  <= 1'b1;
              result_q <= mul_res;
            end
          end
        end
        DIV: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            quot <= quot_next;
            rem  <= rem_next;
            cnt  <= cnt - 1'b1;
            if (cnt == CNTW'(1)) begin
              state    <= DONE;
              valid_q  <= 1'b1;
              result_q <= div_res;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - directed bench for alu_mdu_seq at WIDTH 32 and 8 against a behavioural model
module tb_alu_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.WIDTH(32)) if32 ();
  alu_mdu_seq_if #(.WIDTH(8))  if8 ();

  alu_mdu_seq #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  alu_mdu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
    int          lat;
    int          kill_cyc;
    bit          has_lit;
    logic [31:0] lit;
  } txn_t;

  txn_t tx [2][64];
  int   n_tx [2] = '{0, 0};
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;

  logic [31:0] o_res [2];
  logic        o_busy [2];
  logic        o_valid [2];
  logic        o_zero [2];
  assign o_res[0]   = if32.result;
  assign o_res[1]   = {24'd0, if8.result};
  assign o_busy[0]  = if32.busy;
  assign o_busy[1]  = if8.busy;
  assign o_valid[0] = if32.valid;
  assign o_valid[1] = if8.valid;
  assign o_zero[0]  = if32.zero;
  assign o_zero[1]  = if8.zero;

  // RV32M-style arithmetic on w-bit values using 64-bit integers
  function automatic logic [31:0] model(int w, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub, sa, sb, minv, r;
    int sh;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    minv = -(longint'(1) << (w - 1));
    sh   = int'(ub % longint'(w));
    case (op)
      5'd0:  r = ua & ub;
      5'd1:  r = ua | ub;
      5'd2:  r = ua + ub;
      5'd3:  r = ua - ub;
      5'd4:  r = (sa < sb) ? 1 : 0;
      5'd5:  r = (ua < ub) ? 1 : 0;
      5'd6:  r = ua ^ ub;
      5'd7:  r = ua << sh;
      5'd8:  r = ua >> sh;
      5'd9:  r = sa >>> sh;
      5'd16: r = sa * sb;
      5'd17: r = (sa * sb) >> w;
      5'd18: r = (sa * ub) >> w;
      5'd19: r = (ua * ub) >> w;
      5'd20: r = (ub == 0) ? -1 : ((sa == minv && sb == -1) ? sa : sa / sb);
      5'd21: r = (ub == 0) ? -1 : ua / ub;
      5'd22: r = (ub == 0) ? sa : ((sa == minv && sb == -1) ? 0 : sa % sb);
      5'd23: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic int lat_of(int w, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint mask, ua, ub;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (op >= 5'd16 && op <= 5'd19) return w + 1;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (ub == 0) return 1;
      if (!op[0] && ua == (longint'(1) << (w - 1)) && ub == mask) return 1;
      return w + 1;
    end
    return 1;
  endfunction

  task automatic chk(string name, int l, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s lane%0d cyc=%0d actual=%h required=%h", name, l, cyc, act, exp);
    end
  endtask

  initial begin
    int          head [2];
    logic [31:0] last_res [2];
    logic [31:0] exp;
    txn_t        t;
    bit          infl, eb, ev;
    int          w;
    head     = '{0, 0};
    last_res = '{32'd0, 32'd0};
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int l = 0; l < 2; l++) begin
        w = (l == 0) ? 32 : 8;
        if (!rst_n) begin
          chk("rst_busy", l, 32'(o_busy[l]), 32'd0);
          chk("rst_valid", l, 32'(o_valid[l]), 32'd0);
          chk("rst_result", l, o_res[l], 32'd0);
          chk("rst_zero", l, 32'(o_zero[l]), 32'd0);
          head[l]     = n_tx[l];
          last_res[l] = 32'd0;
        end else begin
          infl = 1'b0;
          if (head[l] < n_tx[l]) begin
            t    = tx[l][head[l]];
            infl = (cyc >= t.acc);
          end
          eb = infl && (cyc < t.kill_cyc);
          ev = eb && (cyc == t.acc + t.lat - 1);
          chk("busy", l, 32'(o_busy[l]), 32'(eb));
          chk("valid", l, 32'(o_valid[l]), 32'(ev));
          if (ev) begin
            exp = model(w, t.op, t.a, t.b);
            chk($sformatf("result_op%0d", t.op), l, o_res[l], exp);
            chk("zero", l, 32'(o_zero[l]),
                32'(model(w, 5'd3, t.a, t.b) == 32'd0));
            if (t.has_lit) chk($sformatf("model_pin_op%0d", t.op), l, exp, t.lit);
            last_res[l] = exp;
          end else begin
            chk("hold", l, o_res[l], last_res[l]);
          end
          if (infl && (cyc >= t.acc + t.lat - 1 || cyc >= t.kill_cyc)) head[l]++;
        end
      end
    end
  end

  task automatic drive(int l, logic s, logic k, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (l == 0) begin
      if32.start = s; if32.kill = k; if32.op = op; if32.a = a; if32.b = b;
    end else begin
      if8.start = s; if8.kill = k; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end
  endtask

  task automatic start_op(int l, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                          bit hl, logic [31:0] lit);
    txn_t t;
    t.op = op; t.a = a; t.b = b;
    t.acc = cyc + 1;
    t.lat = lat_of((l == 0) ? 32 : 8, op, a, b);
    t.kill_cyc = 1 << 30;
    t.has_lit = hl; t.lit = lit;
    tx[l][n_tx[l]] = t;
    n_tx[l] = n_tx[l] + 1;
    drive(l, 1'b1, 1'b0, op, a, b);
    @(negedge clk);
    drive(l, 1'b0, 1'b0, 5'($urandom), $urandom, $urandom);
  endtask

  task automatic issue(int l, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                       bit hl, logic [31:0] lit);
    start_op(l, op, a, b, hl, lit);
    repeat (lat_of((l == 0) ? 32 : 8, op, a, b)) @(negedge clk);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 5'd2,  32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000);
    issue(0, 5'd9,  32'h80000000, 32'h00000004, 1, 32'hF8000000);
    issue(0, 5'd5,  32'h00000001, 32'hFFFFFFFF, 1, 32'h00000001);
    issue(0, 5'd4,  32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001);
    issue(0, 5'd3,  32'h00000000, 32'h00000001, 1, 32'hFFFFFFFF);
    issue(0, 5'd7,  32'h00000001, 32'h00000023, 1, 32'h00000008);
    issue(0, 5'd8,  32'h80000000, 32'h0000001F, 1, 32'h00000001);
    issue(0, 5'd0,  32'h00001234, 32'h00001234, 1, 32'h00001234);
    issue(0, 5'd1,  32'hF0000000, 32'h0000000F, 1, 32'hF000000F);
    issue(0, 5'd10, 32'h12345678, 32'h00000001, 1, 32'h00000000);
    issue(0, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000);

    issue(0, 5'd16, 32'hFFFFFFF9, 32'h00000006, 1, 32'hFFFFFFD6);
    issue(0, 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000);
    issue(0, 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE);
    issue(0, 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);

    issue(0, 5'd20, 32'hFFFFFFEC, 32'h00000003, 1, 32'hFFFFFFFA);
    issue(0, 5'd22, 32'hFFFFFFEC, 32'h00000003, 1, 32'hFFFFFFFE);
    issue(0, 5'd20, 32'h00000005, 32'h00000000, 1, 32'hFFFFFFFF);
    issue(0, 5'd22, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000);
    issue(0, 5'd20, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    issue(0, 5'd23, 32'h00000005, 32'h00000000, 1, 32'h00000005);
    issue(0, 5'd21, 32'h00000064, 32'h00000007, 1, 32'h0000000E);
    issue(0, 5'd22, 32'h00000014, 32'hFFFFFFFD, 1, 32'h00000002);
    issue(0, 5'd20, 32'h00000014, 32'hFFFFFFFD, 1, 32'hFFFFFFFA);

    issue(1, 5'd21, 32'd200, 32'd7, 1, 32'h0000001C);
    issue(1, 5'd23, 32'd200, 32'd7, 1, 32'h00000004);
    issue(1, 5'd16, 32'h0F, 32'h11, 1, 32'h000000FF);
    issue(1, 5'd20, 32'h80, 32'hFF, 1, 32'h00000080);

    // kill in the fifth cycle of a multiply
    start_op(0, 5'd16, 32'h12345678, 32'h9ABCDEF0, 0, 32'd0);
    repeat (4) @(negedge clk);
    tx[0][n_tx[0]-1].kill_cyc = cyc + 1;
    if32.kill = 1'b1;
    @(negedge clk);
    if32.kill = 1'b0;
    repeat (2) @(negedge clk);

    // start while busy is ignored
    start_op(0, 5'd20, 32'hFFFFFF9C, 32'h00000007, 1, 32'hFFFFFFF2);
    repeat (3) @(negedge clk);
    drive(0, 1'b1, 1'b0, 5'd2, 32'd1, 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (29) @(negedge clk);

    // start during the valid cycle is ignored
    start_op(0, 5'd6, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'hF0F0F0F0);
    drive(0, 1'b1, 1'b0, 5'd2, 32'd5, 32'd5);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    // kill together with start in idle accepts nothing
    drive(0, 1'b1, 1'b1, 5'd2, 32'd3, 32'd4);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    issue(0, 5'd2, 32'd3, 32'd4, 1, 32'd7);

    // reset in the middle of an unsigned divide
    start_op(0, 5'd21, 32'd1000, 32'd7, 0, 32'd0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(0, 5'd21, 32'd1000, 32'd7, 1, 32'h0000008E);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds the RV32M multiply/divide group as an iterative radix-2 unit (one bit per cycle), plus XOR/shift/unsigned-compare ops.
- Uses a start/busy/valid handshake so the multicycle/pipelined control FSM can stall on long ops.
- Sits in the EX stage beside the existing ALU; shares the operand buses and writes oResult to the register-file write-back mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2, >= 8.
- CNTW, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- iStart  in  1  accept operation; sampled only when oBusy=0.
- iKill  in  1  synchronous abort of the in-flight op (pipeline flush).
- iOp  in  5  operation code, encoding below.
- iA  in  WIDTH  operand A (rs1).
- iB  in  WIDTH  operand B (rs2); shifts use iB[$clog2(WIDTH)-1:0].
- oBusy  out  1  op in flight; new iStart ignored.
- oValid  out  1  one-cycle pulse, oResult/oZero valid.
- oResult  out  WIDTH  result, held until next accepted op.
- oZero  out  1  registered (iA==iB) captured at accept, qualified by oValid.

Behaviour:
- Op codes:
  - Single-cycle: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 XOR, 7 SLL, 8 SRL, 9 SRA.
  - Iterative: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code is NULL: result 0.
- Reset (async, iRST_n=0):
  - State=IDLE; oBusy=0, oValid=0, oResult=0, oZero=0; counter and internal accumulators cleared.
  - Reset asserted mid-operation discards the op with no oValid.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - iStart=1 latches iA, iB, iOp and oZero <= (iA==iB).
  - Single-cycle ops and NULL: result is computed and registered in the same edge, go to DONE (latency 1).
  - MUL* ops: go to MUL with counter=WIDTH.
  - DIV/REM ops: go to DIV with counter=WIDTH, except the special cases below.
- Divide special cases go directly to DONE (latency 1):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (A = most-negative, B = -1): quotient = A; remainder = 0.
- MUL:
  - Operands are made non-negative per signedness: MUL and MULH treat both as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Shift-add one bit per cycle into a 2*WIDTH product.
  - When counter reaches 0, negate the product if the sign flag is set. MUL returns product[WIDTH-1:0]; the others return product[2*WIDTH-1:WIDTH]. Go to DONE.
  - Latency WIDTH+1 cycles from accept to oValid.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign A XOR sign B; remainder sign = sign A (signed ops only).
  - Latency WIDTH+1.
- DONE: oValid=1 for exactly one cycle, then IDLE.
- oBusy=1 in every state except IDLE; iStart in the DONE cycle is ignored.
- Back-to-back single-cycle ops therefore have throughput one per 2 cycles.
- iKill=1 in MUL/DIV/DONE: go to IDLE next edge, oValid suppressed, oResult keeps its previous value. iKill in IDLE has no effect. iKill and iStart together in IDLE: iKill wins, nothing is accepted.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. SLT is signed, SLTU unsigned; both return the 0/1 result zero-extended. SRA sign-fills.
- Operand changes after accept have no effect.

Test Plan:
- Reset mid-DIV (iRST_n low at cycle 10 of a DIVU) -> all outputs 0 immediately, no oValid after release, next op accepted normally.
- WIDTH=32, ADD A=0x7FFFFFFF B=1 -> oValid 1 cycle after accept, oResult=0x80000000, oZero=0. Also SRA A=0x80000000 B=4 -> 0xF8000000. Also SLTU A=1 B=0xFFFFFFFF -> 1.
- MULH A=0xFFFFFFFF(-1) B=0xFFFFFFFF -> oResult=0 at 33 cycles; MULHU same operands -> 0xFFFFFFFE; MUL A=-7 B=6 -> 0xFFFFFFD6.
- DIV A=-20 B=3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; DIV A=5 B=0 -> 0xFFFFFFFF at 1 cycle; REM A=0x80000000 B=-1 -> 0.
- iKill at cycle 5 of a MUL -> oBusy low next cycle, no oValid, oResult unchanged; iStart while busy -> ignored, the original result is delivered.
- WIDTH=8 regression: DIVU 200/7 -> 28, REMU -> 4, latency 9 cycles.
